// File: rtl/if_fetch_queue_if.sv
// Fetch/decode side of the IF->ID queue: push handshake from fetch and head view to decode.
// Push is a strict valid/ready handshake. An entry transfers on a rising edge where push_valid
// and push_ready are both 1. push_ready never depends on push_valid. Decode consumes the head
// on an edge where if_en and id_ready are both 1.
interface if_fetch_queue_if #(
  parameter int PC_W   = 32,
  parameter int INSN_W = 32,
  parameter int DEPTH  = 4
);
  logic                     push_valid;
  logic                     push_ready;
  logic [PC_W-1:0]          push_pc;
  logic [INSN_W-1:0]        push_insn;
  logic                     push_predt_br_taken;
  logic                     id_ready;
  logic                     if_en;
  logic [PC_W-1:0]          if_pc;
  logic [INSN_W-1:0]        if_insn;
  logic                     if_predt_br_taken;
  logic [$clog2(DEPTH):0]   fq_count;
  logic                     fq_afull;

  modport master (
    output push_valid, push_pc, push_insn, push_predt_br_taken, id_ready,
    input  push_ready, if_en, if_pc, if_insn, if_predt_br_taken, fq_count, fq_afull
  );

  modport slave (
    input  push_valid, push_pc, push_insn, push_predt_br_taken, id_ready,
    output push_ready, if_en, if_pc, if_insn, if_predt_br_taken, fq_count, fq_afull
  );
endinterface

// File: rtl/if_fetch_queue.sv
// IF->ID decoupling FIFO: DEPTH entries of {pc, insn, predicted-taken}.
// The head entry drives the ID stage; flush empties the queue in one cycle.
module if_fetch_queue #(
  parameter int PC_W      = 32,
  parameter int INSN_W    = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_en,
  input  logic            if_flush,
  if_fetch_queue_if.slave fq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [INSN_W-1:0] insn_mem  [DEPTH];
  logic              predt_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty = (count != '0);
  assign fq.push_ready = (count != FULL_CNT);
  assign push = fq.push_valid & fq.push_ready;
  assign pop  = fq.id_ready & not_empty;

  // Pointers and count; cpu_en=0 freezes everything, flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (cpu_en) begin
      if (if_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Storage is not reset; the head view is masked while empty.
  always_ff @(posedge clk) begin
    if (cpu_en && !if_flush && push) begin
      pc_mem[wr_ptr]    <= fq.push_pc;
      insn_mem[wr_ptr]  <= fq.push_insn;
      predt_mem[wr_ptr] <= fq.push_predt_br_taken;
    end
  end

  assign fq.if_en             = not_empty;
  assign fq.if_pc             = not_empty ? pc_mem[rd_ptr]    : '0;
  assign fq.if_insn           = not_empty ? insn_mem[rd_ptr]  : '0;
  assign fq.if_predt_br_taken = not_empty ? predt_mem[rd_ptr] : 1'b0;
  assign fq.fq_count          = count;
  assign fq.fq_afull          = (count >= AFULL_CNT);
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=4, AFULL_LVL=3): vector table plus reset sequences.
`timescale 1ns/100ps
module tb_if_fetch_queue;
  localparam int PC_W   = 32;
  localparam int INSN_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [31:0] INSN_X = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  logic cpu_en;
  logic if_flush;

  int total = 0;
  int bad   = 0;

  if_fetch_queue_if #(.PC_W(PC_W), .INSN_W(INSN_W), .DEPTH(DEPTH)) fq ();

  if_fetch_queue #(.PC_W(PC_W), .INSN_W(INSN_W), .DEPTH(DEPTH), .AFULL_LVL(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_en   (cpu_en),
    .if_flush (if_flush),
    .fq       (fq.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        flush;
    logic        pv;
    logic [31:0] pc;
    logic        pt;
    logic        rdy;
    logic        x_en;
    logic [31:0] x_pc;
    logic        x_pt;
    logic [2:0]  x_cnt;
    logic        x_prdy;
    logic        x_afull;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic flush, input logic pv,
                              input logic [31:0] pc, input logic pt, input logic rdy,
                              input logic x_en, input logic [31:0] x_pc, input logic x_pt,
                              input logic [2:0] x_cnt, input logic x_prdy, input logic x_afull);
    vec_t v;
    v.en = en; v.flush = flush; v.pv = pv; v.pc = pc; v.pt = pt; v.rdy = rdy;
    v.x_en = x_en; v.x_pc = x_pc; v.x_pt = x_pt; v.x_cnt = x_cnt;
    v.x_prdy = x_prdy; v.x_afull = x_afull;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic x_en, input logic [31:0] x_pc,
                               input logic x_pt, input logic [2:0] x_cnt,
                               input logic x_prdy, input logic x_afull);
    check({tag, "_if_en"},   64'(fq.if_en), 64'(x_en));
    check({tag, "_if_pc"},   64'(fq.if_pc), 64'(x_pc));
    check({tag, "_if_insn"}, 64'(fq.if_insn), x_en ? 64'(x_pc ^ INSN_X) : 64'd0);
    check({tag, "_predt"},   64'(fq.if_predt_br_taken), 64'(x_pt));
    check({tag, "_count"},   64'(fq.fq_count), 64'(x_cnt));
    check({tag, "_prdy"},    64'(fq.push_ready), 64'(x_prdy));
    check({tag, "_afull"},   64'(fq.fq_afull), 64'(x_afull));
  endtask

  // driver: inputs change 1 ns after a rising edge, outputs sampled 1 ns after the next one
  task automatic drive(input logic en, input logic flush, input logic pv,
                       input logic [31:0] pc, input logic pt, input logic rdy);
    cpu_en                 = en;
    if_flush               = flush;
    fq.push_valid          = pv;
    fq.push_pc             = pc;
    fq.push_insn           = pc ^ INSN_X;
    fq.push_predt_br_taken = pt;
    fq.id_ready            = rdy;
  endtask

  task automatic step(input logic en, input logic flush, input logic pv,
                      input logic [31:0] pc, input logic pt, input logic rdy);
    drive(en, flush, pv, pc, pt, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill to full with id_ready=0, attempt an overwrite, then drain in order
    add(1,0,1,32'h100,0,0, 1,32'h100,0,3'd1,1,0);
    add(1,0,1,32'h104,0,0, 1,32'h100,0,3'd2,1,0);
    add(1,0,1,32'h108,0,0, 1,32'h100,0,3'd3,1,1);
    add(1,0,1,32'h10C,0,0, 1,32'h100,0,3'd4,0,1);
    add(1,0,1,32'h1F0,1,0, 1,32'h100,0,3'd4,0,1);
    add(1,0,0,32'h0,0,1,   1,32'h104,0,3'd3,1,1);
    add(1,0,0,32'h0,0,1,   1,32'h108,0,3'd2,1,0);
    add(1,0,0,32'h0,0,1,   1,32'h10C,0,3'd1,1,0);
    add(1,0,0,32'h0,0,1,   0,32'h0,0,3'd0,1,0);
    add(1,0,0,32'h0,0,1,   0,32'h0,0,3'd0,1,0);
    // wrap-around: 10 simultaneous push+pop cycles at occupancy 1
    add(1,0,1,32'h300,1,0, 1,32'h300,1,3'd1,1,0);
    for (int k = 0; k < 10; k++) begin
      logic [31:0] p;
      p = 32'h304 + 32'(4 * k);
      add(1,0,1,p,k[0],1, 1,p,k[0],3'd1,1,0);
    end
    add(1,0,0,32'h0,0,1,   0,32'h0,0,3'd0,1,0);
    // stall hold on head 0x200 predt=1 while pushes continue until full
    add(1,0,1,32'h200,1,0, 1,32'h200,1,3'd1,1,0);
    add(1,0,1,32'h204,0,0, 1,32'h200,1,3'd2,1,0);
    add(1,0,1,32'h208,0,0, 1,32'h200,1,3'd3,1,1);
    add(1,0,1,32'h20C,0,0, 1,32'h200,1,3'd4,0,1);
    add(1,0,1,32'h210,0,0, 1,32'h200,1,3'd4,0,1);
    add(1,0,0,32'h0,0,1,   1,32'h204,0,3'd3,1,1);
    add(1,0,0,32'h0,0,1,   1,32'h208,0,3'd2,1,0);
    // flush at count=2 with concurrent push and pop; pushed pc must never appear
    add(1,1,1,32'h400,1,1, 0,32'h0,0,3'd0,1,0);
    add(1,0,0,32'h0,0,1,   0,32'h0,0,3'd0,1,0);
    // cpu_en=0 for 3 cycles with push_valid and id_ready high, then resume
    add(1,0,1,32'h500,0,0, 1,32'h500,0,3'd1,1,0);
    add(1,0,1,32'h504,1,0, 1,32'h500,0,3'd2,1,0);
    add(0,0,1,32'h5F0,0,1, 1,32'h500,0,3'd2,1,0);
    add(0,0,1,32'h5F4,0,1, 1,32'h500,0,3'd2,1,0);
    add(0,1,1,32'h5F8,0,1, 1,32'h500,0,3'd2,1,0);
    add(1,0,1,32'h508,0,1, 1,32'h504,1,3'd2,1,0);
    add(1,0,0,32'h0,0,1,   1,32'h508,0,3'd1,1,0);
    add(1,0,0,32'h0,0,1,   0,32'h0,0,3'd0,1,0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].flush, vecs[i].pv, vecs[i].pc, vecs[i].pt, vecs[i].rdy);
      check_outputs($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_pc, vecs[i].x_pt,
                    vecs[i].x_cnt, vecs[i].x_prdy, vecs[i].x_afull);
    end

    // no same-cycle bypass: a push presented to an empty queue is invisible before the edge
    drive(1'b1, 1'b0, 1'b1, 32'h600, 1'b1, 1'b1);
    #2;
    check("no_bypass_if_en", 64'(fq.if_en), 64'd0);
    check("no_bypass_if_pc", 64'(fq.if_pc), 64'd0);
    @(posedge clk);
    #1;
    check_outputs("latency", 1'b1, 32'h600, 1'b1, 3'd1, 1'b1, 1'b0);

    // reset mid-traffic: three entries held, then a 1 ns async reset pulse
    step(1'b1, 1'b0, 1'b1, 32'h604, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h608, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_outputs("pre_rst", 1'b1, 32'h600, 1'b1, 3'd3, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0);
    check_outputs("post_rst_push", 1'b1, 32'h700, 1'b0, 3'd1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 ns");
    $fatal(1, "timeout");
  end
endmodule
